mash_dsm: RTL
=============

// Module: mash_dsm
// PURPOSE
//  Parametrised MASH 1-1-1 digital delta-sigma modulator for the fractional-N PLL divider.
//  Successor of the first-order DSM: WIDTH-bit fractional word and runtime-selectable order (1, 2 or 3).
//  Adds an enable, a double-buffered fractional-word load and a registered divide-ratio output.
//  Sits between the frequency-control register and the multi-modulus divider; clocked by the divider output.
// PARAMETERS
//  WIDTH   16  fractional word / accumulator width (4..32)
//  NINT_W  8   integer divide-ratio width
//  INIT1   1   reset value of accumulator 1 (odd value = LSB dither, breaks idle tones)
// PORTS
//  clk         in   1         rising-edge clock (divider output)
//  rst         in   1         synchronous reset, active-high
//  en          in   1         advance modulator this cycle; low = hold all state
//  order       in   2         1,2,3 = MASH order; 0 treated as 1
//  alpha_in    in   WIDTH     new fractional word (unsigned, value alpha/2^WIDTH)
//  alpha_load  in   1         1-cycle strobe: capture alpha_in into shadow register
//  n_int       in   NINT_W    integer divide ratio
//  y           out  4         signed modulator output, two's complement
//  div_ratio   out  NINT_W+1  n_int + y, unsigned, to divider
//  load_ack    out  1         1-cycle pulse when shadow word becomes active
// BEHAVIOUR
//  Clock and reset: single clock clk; rst is synchronous, active-high; checked before en.
//  Reset: acc1=INIT1, acc2=acc3=0, all carry-delay regs 0, shadow=active=0, y=0,
//   div_ratio=0, load_ack=0. rst wins over simultaneous alpha_load/en.
//  Word load: alpha_load -> shadow<=alpha_in (regardless of en). Shadow copied into active
//   word on the next cycle with en=1; load_ack pulses that cycle. Pending load never lost;
//   second alpha_load before transfer overwrites shadow (last wins, one ack).
//  Per cycle with en=1 (all sums mod 2^WIDTH, carry = bit WIDTH of the (WIDTH+1)-bit sum):
//   s1=acc1+active; c1=carry; acc1<=s1
//   s2=acc2+s1[WIDTH-1:0]; c2=carry; acc2<=s2
//   s3=acc3+s2[WIDTH-1:0]; c3=carry; acc3<=s3
//   c2d<=c2; c3d<=c3; c3dd<=c3d
//   y<= c1                                   (order 1)
//   y<= c1 + c2 - c2d                        (order 2)
//   y<= c1 + c2 - c2d + c3 - 2*c3d + c3dd    (order 3)
//  The active word used this cycle is the post-transfer value if a transfer occurs.
//  Ranges: order1 {0,1}; order2 {-1..2}; order3 {-3..4}; 4-bit signed never overflows.
//  Latency: y and div_ratio update on the same edge as accumulators (1 clk after en sampled).
//   div_ratio<=n_int+sign_extend(y_next); n_int sampled that cycle; n_int must exceed 3.
//  en=0: accumulators, delays, y, div_ratio held; load_ack=0.
//  Order change mid-run: accumulators keep running at all orders (stages 2/3 always
//   clocked), only combination changes; new order applies at next enabled edge.
//  Mean: over 2^WIDTH enabled cycles, sum(y) = active word exactly (any order, constant word).
//  alpha=0 with INIT1=0: y=0 forever. Accumulator wrap is the intended modulo behaviour.
// TESTING
//  T1 WIDTH=4,INIT1=0,order=1,alpha=4 loaded, en=1: y=0,0,0,1 repeating; load_ack on 1st en cycle.
//  T2 WIDTH=16,order=3,alpha=0x4000, 65536 cycles: sum(y)=16384, y always in [-3,4].
//  T3 order=2,n_int=40,alpha=0x8000, INIT1=0: div_ratio only in {39..42}, mean 40.5 over 2^16 cycles.
//  T4 alpha_load with en=0 for 5 cycles, then en=1: y/acc unchanged during hold, ack on 1st en cycle.
//  T5 rst asserted mid-run together with alpha_load: next cycle all outputs 0, acc1=INIT1, shadow=0.
//  T6 order switched 3->1 mid-run: y immediately restricted to {0,1}; mean still equals alpha.

Source files
------------

// File: rtl/mash_dsm.sv
// MASH 1-1-1 delta-sigma modulator for a fractional-N divider.
// The order can be changed at runtime, and the fractional word is loaded through a shadow register.
module mash_dsm #(
    parameter int WIDTH  = 16,
    parameter int NINT_W = 8,
    parameter int INIT1  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        order,
    input  logic [WIDTH-1:0]  alpha_in,
    input  logic              alpha_load,
    input  logic [NINT_W-1:0] n_int,
    output logic [3:0]        y,
    output logic [NINT_W:0]   div_ratio,
    output logic              load_ack
);

    logic [WIDTH-1:0]  shadow_q, shadow_d;
    logic              pending_q, pending_d;
    logic [WIDTH-1:0]  active_q, active_d;
    logic [WIDTH-1:0]  acc1_q, acc1_d;
    logic [WIDTH-1:0]  acc2_q, acc2_d;
    logic [WIDTH-1:0]  acc3_q, acc3_d;
    logic              c2d_q, c2d_d;
    logic              c3d_q, c3d_d;
    logic              c3dd_q, c3dd_d;
    logic [3:0]        y_q, y_d;
    logic [NINT_W:0]   div_ratio_q, div_ratio_d;
    logic              load_ack_q, load_ack_d;

    logic [WIDTH-1:0]  word;
    logic [WIDTH:0]    s1, s2, s3;
    logic [3:0]        t1, t2, t3, y_next;
    logic [NINT_W:0]   y_ext;

    always_comb begin
        shadow_d    = shadow_q;
        pending_d   = pending_q;
        active_d    = active_q;
        acc1_d      = acc1_q;
        acc2_d      = acc2_q;
        acc3_d      = acc3_q;
        c2d_d       = c2d_q;
        c3d_d       = c3d_q;
        c3dd_d      = c3dd_q;
        y_d         = y_q;
        div_ratio_d = div_ratio_q;
        load_ack_d  = 1'b0;

        // A pending word takes effect in the same enabled cycle that transfers it.
        word = (en && pending_q) ? shadow_q : active_q;

        s1 = {1'b0, acc1_q} + {1'b0, word};
        s2 = {1'b0, acc2_q} + {1'b0, s1[WIDTH-1:0]};
        s3 = {1'b0, acc3_q} + {1'b0, s2[WIDTH-1:0]};

        t1 = {3'b000, s1[WIDTH]};
        t2 = {3'b000, s2[WIDTH]} - {3'b000, c2d_q};
        t3 = {3'b000, s3[WIDTH]} - {2'b00, c3d_q, 1'b0} + {3'b000, c3dd_q};

        case (order)
            2'd2:    y_next = t1 + t2;
            2'd3:    y_next = t1 + t2 + t3;
            default: y_next = t1;
        endcase

        y_ext = {{(NINT_W - 3){y_next[3]}}, y_next};

        if (en && pending_q) begin
            active_d   = shadow_q;
            pending_d  = 1'b0;
            load_ack_d = 1'b1;
        end

        if (en) begin
            acc1_d      = s1[WIDTH-1:0];
            acc2_d      = s2[WIDTH-1:0];
            acc3_d      = s3[WIDTH-1:0];
            c2d_d       = s2[WIDTH];
            c3d_d       = s3[WIDTH];
            c3dd_d      = c3d_q;
            y_d         = y_next;
            div_ratio_d = {1'b0, n_int} + y_ext;
        end

        // A load arriving on the transfer cycle becomes the next pending word.
        if (alpha_load) begin
            shadow_d  = alpha_in;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q    <= '0;
            pending_q   <= 1'b0;
            active_q    <= '0;
            acc1_q      <= WIDTH'(INIT1);
            acc2_q      <= '0;
            acc3_q      <= '0;
            c2d_q       <= 1'b0;
            c3d_q       <= 1'b0;
            c3dd_q      <= 1'b0;
            y_q         <= '0;
            div_ratio_q <= '0;
            load_ack_q  <= 1'b0;
        end else begin
            shadow_q    <= shadow_d;
            pending_q   <= pending_d;
            active_q    <= active_d;
            acc1_q      <= acc1_d;
            acc2_q      <= acc2_d;
            acc3_q      <= acc3_d;
            c2d_q       <= c2d_d;
            c3d_q       <= c3d_d;
            c3dd_q      <= c3dd_d;
            y_q         <= y_d;
            div_ratio_q <= div_ratio_d;
            load_ack_q  <= load_ack_d;
        end
    end

    assign y         = y_q;
    assign div_ratio = div_ratio_q;
    assign load_ack  = load_ack_q;

endmodule
